// File: rtl/esm_pkg.sv
// esm_pkg -- shared definitions for the in-order issue buffer (esm).
//   Instruction field positions (RV32I), register-file size, the NOP/bubble
//   value and the FIFO entry layout used by esm and esm_fifo.
package esm_pkg;

   localparam int INSTR_W  = 32;   // entry instruction width (RV32I)
   localparam int REG_AW   = 5;    // register index width
   localparam int NUM_REGS = 32;   // architectural registers x0..x31
   localparam int RD_LSB   = 7;    // rd  = instr[11:7]
   localparam int RS1_LSB  = 15;   // rs1 = instr[19:15]
   localparam int RS2_LSB  = 20;   // rs2 = instr[24:20]

   localparam logic [INSTR_W-1:0] NOP = '0;   // all-zero word = no instruction / bubble

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic               reg_write;
      logic               alu_src;
   } entry_t;

endpackage

// File: rtl/esm_fifo.sv
// esm_fifo -- in-order FIFO of DEPTH entries, DW bits each.
//   clk, rst : clock, synchronous active-high reset (empties the FIFO)
//   push/din : write din at the tail (ignored when full, unless popping too)
//   pop/dout : dout is the current head; pop removes it (ignored when empty)
//   full, empty, count : occupancy, count ranges 0..DEPTH
module esm_fifo #(
   parameter int DEPTH = 16,
   parameter int DW    = 34
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [DW-1:0]            din,
   output logic [DW-1:0]            dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [AW:0]   count_q, count_d;
   logic          do_push, do_pop;

   assign full  = (count_q == (AW+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign dout  = mem_q[rptr_q];

   // A push into a full FIFO is accepted only when the head leaves on the same edge.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_comb begin
      // Power-of-two depth: pointer overflow is the modulo wrap.
      wptr_d  = wptr_q + {{(AW-1){1'b0}}, do_push};
      rptr_d  = rptr_q + {{(AW-1){1'b0}}, do_pop};
      count_d = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset: only slots between the pointers are ever read.
   always_ff @(posedge clk) begin
      if (!rst && do_push) mem_q[wptr_q] <= din;
   end

endmodule

// File: rtl/esm.sv
// esm -- in-order instruction buffer with scoreboard-based issue.
//   clk, rst  : clock, synchronous active-high reset
//   Instr_in  : offered instruction (0 = none), with RegWrite / ALUSrc flags
//   Instr_out : registered issued instruction (0 = bubble)
// Instructions queue in esm_fifo; the head issues when neither of its source
// registers has a pending write. Each register has a 2-bit countdown set to
// LAT when a writer issues.
module esm
   import esm_pkg::*;
#(
   parameter int Instruction_word_size = 32,
   parameter int bs                    = 16,
   parameter int LAT                   = 2
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [Instruction_word_size-1:0] Instr_in,
   input  logic                             RegWrite,
   input  logic                             ALUSrc,
   output logic [Instruction_word_size-1:0] Instr_out
);

   localparam logic [1:0] LAT_V = 2'(LAT);

   entry_t                  push_entry, head;
   logic                    fifo_full, fifo_empty;
   logic [$clog2(bs):0]     fifo_count;
   logic                    push, issue, hazard;
   logic [REG_AW-1:0]       rs1, rs2, rd;

   logic [1:0]                       busy_q [NUM_REGS];
   logic [1:0]                       busy_d [NUM_REGS];
   logic [Instruction_word_size-1:0] instr_out_q, instr_out_d;

   assign push_entry.instr     = INSTR_W'(Instr_in);
   assign push_entry.reg_write = RegWrite;
   assign push_entry.alu_src   = ALUSrc;

   assign rs1 = head.instr[RS1_LSB +: REG_AW];
   assign rs2 = head.instr[RS2_LSB +: REG_AW];
   assign rd  = head.instr[RD_LSB  +: REG_AW];

   // Field decode is opcode-blind: every head is checked on rs1, and on rs2
   // unless it takes an immediate.
   assign hazard = ((rs1 != '0) && (busy_q[rs1] != 2'd0)) ||
                   (!head.alu_src && (rs2 != '0) && (busy_q[rs2] != 2'd0));
   assign issue  = !fifo_empty && !hazard;
   assign push   = (Instr_in != '0) && (!fifo_full || issue);

   esm_fifo #(
      .DEPTH (bs),
      .DW    ($bits(entry_t))
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (issue),
      .din   (push_entry),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_comb begin
      instr_out_d = issue ? Instruction_word_size'(head.instr) : Instruction_word_size'(NOP);
      for (int r = 0; r < NUM_REGS; r++) begin
         busy_d[r] = busy_q[r];
         if (busy_q[r] != 2'd0) busy_d[r] = busy_q[r] - 2'd1;
      end
      // A new writer's countdown overrides the same-edge decrement.
      if (issue && head.reg_write && (rd != '0)) busy_d[rd] = LAT_V;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         instr_out_q <= '0;
         for (int r = 0; r < NUM_REGS; r++) busy_q[r] <= 2'd0;
      end else begin
         instr_out_q <= instr_out_d;
         for (int r = 0; r < NUM_REGS; r++) busy_q[r] <= busy_d[r];
      end
   end

   assign Instr_out = instr_out_q;

endmodule

// File: tb/tb_esm.sv
// tb_esm -- directed and random checks of esm against a ready-time model:
// each register remembers the first edge at which a reader may issue, and the
// buffer is a plain queue of offered instructions.
module tb_esm;

   localparam int BS  = 16;
   localparam int LAT = 2;

   typedef struct {
      logic [31:0] instr;
      bit          rw;
      bit          as;
   } ment_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] Instr_in = '0;
   logic        RegWrite = 1'b0;
   logic        ALUSrc = 1'b0;
   logic [31:0] Instr_out;

   int          n_cmp = 0;
   int          n_err = 0;
   ment_t       mq[$];
   int          avail [32];
   int          t = 0;
   logic [31:0] last_out;
   logic [31:0] obs [6];
   int          drained;

   esm #(.Instruction_word_size(32), .bs(BS), .LAT(LAT)) dut (
      .clk       (clk),
      .rst       (rst),
      .Instr_in  (Instr_in),
      .RegWrite  (RegWrite),
      .ALUSrc    (ALUSrc),
      .Instr_out (Instr_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      n_cmp++;
      assert (o === e) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   // Expected behaviour of one rising edge.
   task automatic model_edge(input bit r, input logic [31:0] ins, input bit rw, input bit as,
                             output logic [31:0] e);
      bit    ok;
      ment_t h, n;
      int    s1, s2, d;
      e = '0;
      if (r) begin
         mq.delete();
         for (int i = 0; i < 32; i++) avail[i] = 0;
      end else begin
         if (mq.size() > 0) begin
            h  = mq[0];
            s1 = int'(h.instr[19:15]);
            s2 = int'(h.instr[24:20]);
            d  = int'(h.instr[11:7]);
            ok = (s1 == 0 || avail[s1] <= t) && (h.as || s2 == 0 || avail[s2] <= t);
            if (ok) begin
               e = h.instr;
               void'(mq.pop_front());
               if (h.rw && d != 0) avail[d] = t + LAT + 1;
            end
         end
         if (ins != 0 && mq.size() < BS) begin
            n.instr = ins; n.rw = rw; n.as = as;
            mq.push_back(n);
         end
      end
      t++;
   endtask

   task automatic step(input bit r, input logic [31:0] ins, input bit rw, input bit as,
                       input string tag);
      logic [31:0] e;
      rst = r; Instr_in = ins; RegWrite = rw; ALUSrc = as;
      @(posedge clk);
      model_edge(r, ins, rw, as, e);
      #1;
      last_out = Instr_out;
      chk({tag, ".out"}, Instr_out, e);
      chk({tag, ".cnt"}, 32'(dut.fifo_count), 32'(mq.size()));
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b0, tag);
   endtask

   task automatic chk_busy_clear(input string tag);
      for (int r = 0; r < 32; r++)
         chk($sformatf("%s.busy%0d", tag, r), 32'(dut.busy_q[r]), 32'h0);
   endtask

   initial begin
      logic [31:0] ri;
      bit          rr;

      // Reset, then idle.
      #1;
      step(1'b1, 32'h0, 1'b0, 1'b0, "rst");
      step(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, "rst_in_ignored");
      idle(3, "idle");
      chk("idle.out0", Instr_out, 32'h0);
      chk("idle.cnt0", 32'(dut.fifo_count), 32'h0);

      // Dependent chain: two bubbles before add x3,x1,x2.
      step(1'b0, 32'h00A00093, 1'b1, 1'b1, "chain"); obs[0] = last_out;
      step(1'b0, 32'h01400113, 1'b1, 1'b1, "chain"); obs[1] = last_out;
      step(1'b0, 32'h002081B3, 1'b1, 1'b0, "chain"); obs[2] = last_out;
      idle(1, "chain"); obs[3] = last_out;
      idle(1, "chain"); obs[4] = last_out;
      idle(1, "chain"); obs[5] = last_out;
      chk("chain.seq1", obs[1], 32'h00A00093);
      chk("chain.seq2", obs[2], 32'h01400113);
      chk("chain.seq3", obs[3], 32'h0);
      chk("chain.seq4", obs[4], 32'h0);
      chk("chain.seq5", obs[5], 32'h002081B3);
      idle(4, "chain_tail");

      // Independent lui/auipc issue back to back.
      step(1'b0, 32'h004004B7, 1'b1, 1'b1, "indep");
      step(1'b0, 32'h00800517, 1'b1, 1'b1, "indep"); obs[1] = last_out;
      idle(1, "indep"); obs[2] = last_out;
      chk("indep.seq1", obs[1], 32'h004004B7);
      chk("indep.seq2", obs[2], 32'h00800517);
      idle(3, "indep_tail");

      // Store does not mark its rd field busy; readers of x8 and x5 flow through.
      step(1'b0, 32'h0042A423, 1'b0, 1'b0, "store");
      step(1'b0, 32'h00140313, 1'b1, 1'b1, "store"); obs[1] = last_out;
      step(1'b0, 32'h00128393, 1'b1, 1'b1, "store"); obs[2] = last_out;
      idle(1, "store"); obs[3] = last_out;
      chk("store.seq1", obs[1], 32'h0042A423);
      chk("store.seq2", obs[2], 32'h00140313);
      chk("store.seq3", obs[3], 32'h00128393);
      idle(4, "store_tail");

      // Saturate the buffer with a self-dependent chain, then drain fully.
      for (int i = 0; i < 40; i++) step(1'b0, 32'h00108093, 1'b1, 1'b1, "fill");
      chk("fill.full", 32'(dut.fifo_count), 32'd16);
      drained = 0;
      for (int i = 0; i < 60; i++) begin
         idle(1, "drain");
         if (last_out != 0) begin
            drained++;
            chk("drain.val", last_out, 32'h00108093);
         end
      end
      chk("drain.n", 32'(drained), 32'd16);
      chk("drain.empty", 32'(dut.fifo_count), 32'h0);

      // Reset in the middle of a drain discards everything.
      for (int i = 0; i < 20; i++) step(1'b0, 32'h00108093, 1'b1, 1'b1, "refill");
      idle(4, "middrain");
      step(1'b1, 32'h00108093, 1'b1, 1'b1, "midrst");
      chk("midrst.out", Instr_out, 32'h0);
      chk("midrst.cnt", 32'(dut.fifo_count), 32'h0);
      chk_busy_clear("midrst");
      step(1'b0, 32'h00A00093, 1'b1, 1'b1, "first_after_rst");
      chk("first_after_rst.cnt", 32'(dut.fifo_count), 32'd1);
      idle(4, "post_rst");

      // Random traffic on x0..x3 to provoke hazards, occasional resets.
      for (int i = 0; i < 400; i++) begin
         ri = $urandom;
         ri[11:7]  = 5'($urandom_range(0, 3));
         ri[19:15] = 5'($urandom_range(0, 3));
         ri[24:20] = 5'($urandom_range(0, 3));
         ri[0]     = 1'b1;
         if ($urandom_range(0, 3) == 0) ri = '0;
         rr = ($urandom_range(0, 63) == 0);
         step(rr, ri, 1'($urandom), 1'($urandom), "rand");
      end
      idle(60, "rand_drain");
      chk("rand.empty", 32'(dut.fifo_count), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/esm.md
ESM -- requirements
Module: esm

Interface
REQ-001 SHALL have parameter Instruction_word_size, default 32, instruction width in bits (RV32I encoding).
REQ-002 SHALL have parameter bs, default 16, instruction buffer depth in entries (power of two, at least 2).
REQ-003 SHALL have parameter LAT, default 2, scoreboard busy latency in cycles (1..3).
REQ-004 Clock and reset SHALL be: one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 Instr_in  input  Instruction_word_size  instruction offered this cycle; all-zero means no instruction.
REQ-008 RegWrite  input  1  Instr_in writes its rd field (bits 11:7).
REQ-009 ALUSrc  input  1  Instr_in uses an immediate, so rs2 (bits 24:20) is not a source.
REQ-010 Instr_out  output  Instruction_word_size  registered instruction issued this cycle; all-zero means bubble.

Function
REQ-011 Storage SHALL be an in-order FIFO of bs entries; each entry holds {instruction, RegWrite, ALUSrc}.
REQ-012 Enqueue on an edge SHALL occur when Instr_in is nonzero and (count < bs, or an issue happens on the same edge).
REQ-013 A nonzero Instr_in arriving while the FIFO is full and no issue occurs SHALL be silently dropped, with no state change.
REQ-014 Issue candidate SHALL be the FIFO head only, using the pre-edge contents; an instruction enqueued on edge N is first eligible on edge N+1.
REQ-015 The head SHALL be hazard-free when busy[rs1] is 0 and, if its ALUSrc is 0, busy[rs2] is 0; register x0 SHALL never be busy.
REQ-016 Hazard check SHALL apply to every instruction regardless of opcode, using fields rs1 = bits 19:15 and rs2 = bits 24:20.
REQ-017 On each edge, a non-empty, hazard-free head SHALL be loaded into Instr_out and popped; otherwise Instr_out SHALL be loaded with 0.
REQ-018 Throughput SHALL be at most one enqueue and one issue per cycle; simultaneous enqueue and issue SHALL leave count unchanged.
REQ-019 Scoreboard SHALL hold one counter per architectural register (32 counters, each 2 bits wide).
REQ-020 Each nonzero counter SHALL decrement by 1 per edge.
REQ-021 On issue of an entry with RegWrite=1 and rd != 0, busy[rd] SHALL be set to LAT; this set SHALL take priority over a same-edge decrement.
REQ-022 Entries with RegWrite=0 (branch, store) SHALL not modify the scoreboard.
REQ-023 Minimum latency, empty FIFO with no hazard: Instr_in valid before edge N SHALL appear on Instr_out after edge N+1.
REQ-024 A consumer whose producer issued on edge P SHALL issue no earlier than edge P+LAT+1, giving LAT bubbles in back-to-back chains.
REQ-025 Read and write pointers SHALL wrap modulo bs; count SHALL range 0..bs.

Reset
REQ-026 While rst is high at an edge: FIFO emptied, count=0, pointers=0, all busy counters=0, Instr_out=0.
REQ-027 Inputs SHALL be ignored on reset edges; a mid-operation reset SHALL discard all buffered instructions.
REQ-028 The first enqueue SHALL be possible on the first edge with rst low.

Structure
REQ-029 A shared package esm_pkg SHALL hold the field bit positions (rd, rs1, rs2), the register count (32), the NOP value (0), and the entry typedef.
REQ-030 The FIFO SHALL be a single sub-module, esm_fifo (push, pop, data in/out, full, empty, count).
REQ-031 The scoreboard and issue logic SHALL remain in esm.

Verification
REQ-032 Reset, then idle 3 cycles -> Instr_out=0 and the FIFO is empty.
REQ-033 Back-to-back 00A00093, 01400113, 002081B3 (RegWrite=1; ALUSrc=1,1,0) -> Instr_out sequence 00A00093, 01400113, 0, 0, 002081B3.
REQ-034 Independent 004004B7 then 00800517 (RegWrite=1) -> issued on consecutive cycles, no bubbles.
REQ-035 Store 0042A423 with RegWrite=0, followed by a reader of x5 -> no stall.
REQ-036 40 cycles of dependent 00108093 (addi x1,x1,1) -> count saturates at 16, excess inputs dropped, the 16 buffered instructions drain in order.
REQ-037 rst asserted mid-drain -> next edge Instr_out=0, FIFO empty, scoreboard clear.
